// File: rtl/m_timer_pkg.sv
// Shared definitions for the timer bank: control-register layout and write-select encodings.
package m_timer_pkg;

  // Bit positions inside the control register (wr_data[3:0]).
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_PER = 1;
  localparam int unsigned CTRL_IE  = 2;
  localparam int unsigned CTRL_PRE = 3;

  // wr_sel encodings.
  localparam logic WR_RELOAD = 1'b0;
  localparam logic WR_CTRL   = 1'b1;

  // Field order puts EN in bit 0, matching CTRL_EN..CTRL_PRE.
  typedef struct packed {
    logic pre;
    logic ie;
    logic per;
    logic en;
  } timer_ctrl_t;

endpackage

// File: rtl/m_timer_channel.sv
// One down-counting timer channel: reload, control, live count, terminal pulse and sticky flag.
module m_timer_channel
  import m_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             slow_tick,
  input  logic             wr_reload,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             irq_flag,
  output logic             ie
);

  logic [WIDTH-1:0] reload;
  timer_ctrl_t      ctrl;
  timer_ctrl_t      new_ctrl;
  logic             cnt_event;
  logic             wr_hit;
  logic             terminal;

  assign new_ctrl  = timer_ctrl_t'(wr_data[3:0]);
  assign cnt_event = ctrl.en & (ctrl.pre ? slow_tick : tick);
  // A write to this channel swallows any coincident count event.
  assign wr_hit    = wr_reload | wr_ctrl;
  assign terminal  = cnt_event & ~wr_hit & (count == '0);
  assign ie        = ctrl.ie;

  // Register writes, counting and terminal handling; writes take priority over events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload   <= '0;
      ctrl     <= '0;
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (wr_reload) begin
        reload <= wr_data;
        count  <= wr_data;
      end else if (wr_ctrl) begin
        ctrl <= new_ctrl;
        if (!ctrl.en && new_ctrl.en) begin
          count <= reload;
        end
      end else if (cnt_event) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          tc_pulse <= 1'b1;
          if (ctrl.per) begin
            count <= reload;
          end else begin
            ctrl.en <= 1'b0;
          end
        end
      end
    end
  end

  // Sticky flag: a terminal event in the same cycle as an acknowledge keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_flag <= 1'b0;
    end else if (terminal) begin
      irq_flag <= 1'b1;
    end else if (ack) begin
      irq_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/m_timer_bank.sv
// Bank of NUM_CH programmable down-counters sharing one prescaler and one maskable interrupt.
module m_timer_bank
  import m_timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int PRE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      ack_en,
  input  logic [NUM_CH-1:0]         ack_mask,
  output logic [NUM_CH*WIDTH-1:0]   count,
  output logic [NUM_CH-1:0]         tc_pulse,
  output logic [NUM_CH-1:0]         irq_flag,
  output logic                      irq
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [PRE_WIDTH-1:0] pre;
  logic                 slow_tick;
  logic [NUM_CH-1:0]    ie;

  // Shared free-running prescaler advanced by every base tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= pre + 1'b1;
    end
  end

  assign slow_tick = tick & (&pre);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (wr_ch == CH_W'(c));

    m_timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .slow_tick(slow_tick),
      .wr_reload(sel && (wr_sel == WR_RELOAD)),
      .wr_ctrl  (sel && (wr_sel == WR_CTRL)),
      .wr_data  (wr_data),
      .ack      (ack_en & ack_mask[c]),
      .count    (count[c*WIDTH +: WIDTH]),
      .tc_pulse (tc_pulse[c]),
      .irq_flag (irq_flag[c]),
      .ie       (ie[c])
    );
  end

  assign irq = |(irq_flag & ie);

endmodule

// File: tb/tb_m_timer_bank.sv
// Directed self-checking bench for m_timer_bank (WIDTH=8, NUM_CH=4, PRE_WIDTH=4).
module tb_m_timer_bank;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         wr_en;
  logic         wr_sel;
  logic [1:0]   wr_ch;
  logic [W-1:0] wr_data;
  logic         ack_en;
  logic [N-1:0] ack_mask;
  logic [N*W-1:0] count;
  logic [N-1:0] tc_pulse;
  logic [N-1:0] irq_flag;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;

  m_timer_bank #(.WIDTH(W), .NUM_CH(N), .PRE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_ch(wr_ch), .wr_data(wr_data), .ack_en(ack_en), .ack_mask(ack_mask),
    .count(count), .tc_pulse(tc_pulse), .irq_flag(irq_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cnt(input int c);
    return count[c*W +: W];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input logic [1:0] ch, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_ch = ch; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_ch = '0;
    wr_data = '0; ack_en = 1'b0; ack_mask = '0;
    cyc(); cyc();
    vectors++;
    if (count !== '0 || tc_pulse !== '0 || irq_flag !== '0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: count=%h tc=%b flag=%b irq=%b, want all 0", count, tc_pulse, irq_flag, irq);
    end
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    logic [W-1:0] exp_seq [4] = '{8'd2, 8'd1, 8'd0, 8'd3};
    wr(1'b0, 2'd0, 8'd3);
    wr(1'b1, 2'd0, 8'h03);
    vectors++;
    if (cnt(0) !== 8'd3) begin
      miscompares++; $display("FAIL per_load: count0=%0d want 3", cnt(0));
    end
    tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++;
      if (cnt(0) !== exp_seq[i] || tc_pulse[0] !== (i == 3)) begin
        miscompares++;
        $display("FAIL per_step%0d: count0=%0d tc0=%b want %0d/%b", i, cnt(0), tc_pulse[0], exp_seq[i], (i == 3));
      end
    end
    vectors++;
    if (irq_flag[0] !== 1'b1 || irq !== 1'b0) begin
      miscompares++; $display("FAIL per_flag: flag0=%b irq=%b want 1/0", irq_flag[0], irq);
    end
    cyc();
    vectors++;
    if (cnt(0) !== 8'd2 || tc_pulse[0] !== 1'b0) begin
      miscompares++; $display("FAIL per_after: count0=%0d tc0=%b want 2/0", cnt(0), tc_pulse[0]);
    end
    tick = 1'b0;
    wr(1'b1, 2'd0, 8'h00);
  endtask

  task automatic test_oneshot();
    wr(1'b0, 2'd1, 8'd2);
    wr(1'b1, 2'd1, 8'h05);
    tick = 1'b1;
    cyc(); cyc();
    vectors++;
    if (cnt(1) !== 8'd0 || tc_pulse[1] !== 1'b0) begin
      miscompares++; $display("FAIL os_zero: count1=%0d tc1=%b want 0/0", cnt(1), tc_pulse[1]);
    end
    cyc();
    vectors++;
    if (cnt(1) !== 8'd0 || tc_pulse[1] !== 1'b1 || irq_flag[1] !== 1'b1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL os_term: count1=%0d tc1=%b flag1=%b irq=%b want 0/1/1/1", cnt(1), tc_pulse[1], irq_flag[1], irq);
    end
    cyc(); cyc();
    vectors++;
    if (cnt(1) !== 8'd0 || tc_pulse[1] !== 1'b0 || irq !== 1'b1) begin
      miscompares++; $display("FAIL os_stopped: count1=%0d tc1=%b irq=%b want 0/0/1", cnt(1), tc_pulse[1], irq);
    end
    tick = 1'b0;
    wr(1'b1, 2'd1, 8'h00);
    vectors++;
    if (irq !== 1'b0 || irq_flag[1] !== 1'b1) begin
      miscompares++; $display("FAIL ie_mask: irq=%b flag1=%b want 0/1", irq, irq_flag[1]);
    end
    wr(1'b1, 2'd1, 8'h04);
    vectors++;
    if (irq !== 1'b1 || cnt(1) !== 8'd0) begin
      miscompares++; $display("FAIL ie_unmask: irq=%b count1=%0d want 1/0", irq, cnt(1));
    end
    ack_en = 1'b1; ack_mask = 4'b0010;
    cyc();
    ack_en = 1'b0; ack_mask = '0;
    vectors++;
    if (irq_flag !== 4'b0001 || irq !== 1'b0) begin
      miscompares++; $display("FAIL ack: flag=%b irq=%b want 0001/0", irq_flag, irq);
    end
  endtask

  task automatic test_prescaler();
    rst_pulse();
    wr(1'b0, 2'd2, 8'd1);
    wr(1'b1, 2'd2, 8'h0B);
    tick = 1'b1;
    repeat (15) cyc();
    vectors++;
    if (cnt(2) !== 8'd1) begin
      miscompares++; $display("FAIL pre_15: count2=%0d want 1", cnt(2));
    end
    cyc();
    vectors++;
    if (cnt(2) !== 8'd0 || tc_pulse[2] !== 1'b0) begin
      miscompares++; $display("FAIL pre_16: count2=%0d tc2=%b want 0/0", cnt(2), tc_pulse[2]);
    end
    repeat (15) cyc();
    vectors++;
    if (cnt(2) !== 8'd0 || tc_pulse[2] !== 1'b0) begin
      miscompares++; $display("FAIL pre_31: count2=%0d tc2=%b want 0/0", cnt(2), tc_pulse[2]);
    end
    cyc();
    vectors++;
    if (cnt(2) !== 8'd1 || tc_pulse[2] !== 1'b1) begin
      miscompares++; $display("FAIL pre_32: count2=%0d tc2=%b want 1/1", cnt(2), tc_pulse[2]);
    end
    tick = 1'b0;
  endtask

  task automatic test_write_collision();
    rst_pulse();
    wr(1'b0, 2'd0, 8'd9);
    wr(1'b1, 2'd0, 8'h03);
    wr(1'b0, 2'd3, 8'd7);
    wr(1'b1, 2'd3, 8'h03);
    tick = 1'b1;
    repeat (4) cyc();
    vectors++;
    if (cnt(0) !== 8'd5 || cnt(3) !== 8'd3) begin
      miscompares++; $display("FAIL col_pre: count0=%0d count3=%0d want 5/3", cnt(0), cnt(3));
    end
    wr(1'b0, 2'd0, 8'hA6);
    vectors++;
    if (cnt(0) !== 8'hA6 || cnt(3) !== 8'd2) begin
      miscompares++; $display("FAIL col_hit: count0=%h count3=%0d want a6/2", cnt(0), cnt(3));
    end
    cyc();
    vectors++;
    if (cnt(0) !== 8'hA5 || cnt(3) !== 8'd1) begin
      miscompares++; $display("FAIL col_after: count0=%h count3=%0d want a5/1", cnt(0), cnt(3));
    end
    tick = 1'b0;
  endtask

  task automatic test_set_beats_ack();
    rst_pulse();
    wr(1'b0, 2'd1, 8'd1);
    wr(1'b1, 2'd1, 8'h07);
    tick = 1'b1;
    cyc();
    vectors++;
    if (cnt(1) !== 8'd0 || irq_flag[1] !== 1'b0) begin
      miscompares++; $display("FAIL sa_pre: count1=%0d flag1=%b want 0/0", cnt(1), irq_flag[1]);
    end
    ack_en = 1'b1; ack_mask = 4'b0010;
    cyc();
    vectors++;
    if (irq_flag[1] !== 1'b1 || irq !== 1'b1 || cnt(1) !== 8'd1) begin
      miscompares++; $display("FAIL set_wins: flag1=%b irq=%b count1=%0d want 1/1/1", irq_flag[1], irq, cnt(1));
    end
    cyc();
    vectors++;
    if (irq_flag[1] !== 1'b0) begin
      miscompares++; $display("FAIL sa_ack: flag1=%b want 0", irq_flag[1]);
    end
    ack_en = 1'b0; ack_mask = '0;
    cyc();
    vectors++;
    if (irq_flag[1] !== 1'b1 || tc_pulse[1] !== 1'b1) begin
      miscompares++; $display("FAIL sa_reset: flag1=%b tc1=%b want 1/1", irq_flag[1], tc_pulse[1]);
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (count !== '0 || tc_pulse !== '0 || irq_flag !== '0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: count=%h tc=%b flag=%b irq=%b want all 0", count, tc_pulse, irq_flag, irq);
    end
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    vectors++;
    if (count !== '0 || tc_pulse !== '0 || irq_flag !== '0) begin
      miscompares++; $display("FAIL post_rst: count=%h tc=%b flag=%b want all 0", count, tc_pulse, irq_flag);
    end
    wr(1'b1, 2'd1, 8'h03);
    vectors++;
    if (tc_pulse !== '0 || cnt(1) !== 8'd0) begin
      miscompares++; $display("FAIL rearm_wr: tc=%b count1=%0d want 0000/0", tc_pulse, cnt(1));
    end
    cyc();
    vectors++;
    if (tc_pulse !== 4'b0010 || irq_flag !== 4'b0010) begin
      miscompares++; $display("FAIL rearm_evt: tc=%b flag=%b want 0010/0010", tc_pulse, irq_flag);
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescaler();
    test_write_collision();
    test_set_beats_ack();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
